// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package teclado_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam logic [3:0] IDLE_ROWS = 4'hF;

  // Lowest-numbered active-low row wins when several rows are pulled down.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/teclado_sync.sv
// Two-flop, 4-bit synchronizer for the keypad row returns; idles at all-ones.
module teclado_sync
  import teclado_pkg::*;
(
  input  logic       reloj,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      meta <= IDLE_ROWS;
      q    <= IDLE_ROWS;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/teclado_scan.sv
// 4x4 hex keypad scanner with debounce and 32-bit hex entry register.
// Build option TECLADO_SYNC_EN inserts a two-flop synchronizer on filas.
//
// state    | meaning
// SCAN     | stepping columns, waiting for any low row at a sample point
// DEBOUNCE | column frozen, counting confirming samples of the captured row
// HOLD     | key accepted, column frozen, counting idle samples for release
module teclado_scan
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic        reloj,
  input  logic        reset,
  input  logic [3:0]  filas,
  input  logic        borrar,
  output logic [3:0]  columnas,
  output logic [3:0]  tecla,
  output logic        tecla_valida,
  output logic [31:0] valor,
  output logic        ocupado
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT);

  logic [3:0] filas_s;

`ifdef TECLADO_SYNC_EN
  teclado_sync u_sync (
    .reloj (reloj),
    .reset (reset),
    .d     (filas),
    .q     (filas_s)
  );
`else
  assign filas_s = filas;
`endif

  state_t           state, state_nxt;
  logic [1:0]       col, col_nxt;
  logic [1:0]       row, row_nxt;
  logic [DIV_W-1:0] div;
  logic [DEB_W-1:0] deb, deb_nxt, deb_inc;
  logic             sample;
  logic             accept;

  assign sample   = (div == DIV_LAST);
  assign deb_inc  = deb + 1'b1;
  assign columnas = ~(4'b0001 << col);

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    deb_nxt   = deb;
    accept    = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (filas_s == IDLE_ROWS) begin
            col_nxt = col + 2'd1;
          end else begin
            row_nxt   = low_row(filas_s);
            deb_nxt   = '0;
            state_nxt = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!filas_s[row]) begin
            if (deb_inc == DEB_LAST) begin
              accept    = 1'b1;
              deb_nxt   = '0;
              state_nxt = HOLD;
            end else begin
              deb_nxt = deb_inc;
            end
          end else begin
            // Bounce: drop the candidate and move on to the next column.
            deb_nxt   = '0;
            col_nxt   = col + 2'd1;
            state_nxt = SCAN;
          end
        end
        HOLD: begin
          if (filas_s == IDLE_ROWS) begin
            if (deb_inc == DEB_LAST) begin
              deb_nxt   = '0;
              col_nxt   = col + 2'd1;
              state_nxt = SCAN;
            end else begin
              deb_nxt = deb_inc;
            end
          end else begin
            deb_nxt = '0;
          end
        end
        default: begin
          deb_nxt   = '0;
          state_nxt = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      state        <= SCAN;
      col          <= 2'd0;
      row          <= 2'd0;
      div          <= '0;
      deb          <= '0;
      tecla        <= 4'd0;
      tecla_valida <= 1'b0;
      valor        <= 32'd0;
      ocupado      <= 1'b0;
    end else begin
      state        <= state_nxt;
      col          <= col_nxt;
      row          <= row_nxt;
      deb          <= deb_nxt;
      div          <= sample ? '0 : div + 1'b1;
      tecla_valida <= accept;
      ocupado      <= (state_nxt != SCAN);
      if (accept) tecla <= {row, col};
      // Clear wins over a coincident accept; the digit is dropped from valor.
      if (borrar)      valor <= 32'd0;
      else if (accept) valor <= {valor[27:0], row, col};
    end
  end

endmodule
